// File: rtl/pc_injector.sv
// pc_injector: turns each character-window advance into a round of start tokens.
// Each round offers one token per active character slot on a valid/ready channel.
//
// Build option:
//   PC_INJECTOR_SKIP_EOS_EN  When defined, slots flagged end-of-string are skipped
//                            (mask = enable & ~end_of_s). When undefined, end_of_s
//                            is ignored (mask = enable).
//
// Parameters:
//   PC_WIDTH    width of the PC field of a token
//   CC_ID_BITS  slot index width; slot count S = 2**CC_ID_BITS
//   START_PC    PC value carried by every token
//
// Ports:
//   clk                  clock, all state on its rising edge
//   rst                  asynchronous active-high reset
//   new_char             one-cycle pulse: character window advanced
//   cur_window_enable    per-slot valid mask, sampled on new_char
//   cur_window_end_of_s  per-slot end-of-string mask, sampled on new_char
//   out_valid            token offered
//   out_data             token {slot id, START_PC}
//   out_ready            downstream accepts the token
//   busy                 a round is pending or in progress
//   round_done           one-cycle pulse when a round completes
//   overrun              sticky: a new_char was lost (cleared only by rst)

module pc_injector #(
    parameter int unsigned PC_WIDTH   = 8,
    parameter int unsigned CC_ID_BITS = 1,
    parameter int unsigned START_PC   = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           new_char,
    input  logic [2**CC_ID_BITS-1:0]       cur_window_enable,
    input  logic [2**CC_ID_BITS-1:0]       cur_window_end_of_s,
    output logic                           out_valid,
    output logic [PC_WIDTH+CC_ID_BITS-1:0] out_data,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           round_done,
    output logic                           overrun
);

    localparam int unsigned S = 2 ** CC_ID_BITS;

    typedef enum logic [1:0] {
        StIdle,
        StInject,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [S-1:0]          mask_q, mask_d;
    logic [CC_ID_BITS-1:0] ptr_q, ptr_d;
    logic                  pend_q, pend_d;
    logic [S-1:0]          pend_mask_q, pend_mask_d;
    logic                  overrun_q, overrun_d;

    logic [S-1:0]          m_in;
    logic [S-1:0]          mask_cleared;
    logic [CC_ID_BITS-1:0] k_sel;
    logic                  start_pend;
    logic                  start_new;

`ifdef PC_INJECTOR_SKIP_EOS_EN
    assign m_in = cur_window_enable & ~cur_window_end_of_s;
`else
    logic unused_eos;
    assign unused_eos = ^cur_window_end_of_s;
    assign m_in       = cur_window_enable;
`endif

    // Lowest set mask bit at or above the pointer.
    always_comb begin
        logic found;
        found = 1'b0;
        k_sel = '0;
        for (int unsigned i = 0; i < S; i++) begin
            if (!found && mask_q[i] && (i >= 32'(ptr_q))) begin
                found = 1'b1;
                k_sel = CC_ID_BITS'(i);
            end
        end
    end

    assign mask_cleared = mask_q & ~(S'(1) << k_sel);

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        ptr_d       = ptr_q;
        pend_d      = pend_q;
        pend_mask_d = pend_mask_q;
        overrun_d   = overrun_q;
        start_pend  = 1'b0;
        start_new   = 1'b0;

        case (state_q)
            StIdle: begin
                if (pend_q) begin
                    start_pend = 1'b1;
                end else if (new_char) begin
                    start_new = 1'b1;
                end
            end
            StInject: begin
                if (out_ready) begin
                    mask_d = mask_cleared;
                    // Saturate so the pointer never wraps back to slot 0.
                    ptr_d  = (k_sel == CC_ID_BITS'(S - 1)) ? k_sel : k_sel + 1'b1;
                    if (mask_cleared == '0) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (pend_q) begin
                    start_pend = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_pend) begin
            mask_d  = pend_mask_q;
            ptr_d   = '0;
            pend_d  = 1'b0;
            state_d = (pend_mask_q == '0) ? StDone : StInject;
        end

        if (start_new) begin
            mask_d  = m_in;
            ptr_d   = '0;
            state_d = (m_in == '0) ? StDone : StInject;
        end

        // Any new_char not starting a round goes to the pending slot; the slot
        // counts as free when its contents are being launched this same cycle.
        if (new_char && !start_new) begin
            if (!pend_q || start_pend) begin
                pend_d      = 1'b1;
                pend_mask_d = m_in;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            ptr_q       <= '0;
            pend_q      <= 1'b0;
            pend_mask_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ptr_q       <= ptr_d;
            pend_q      <= pend_d;
            pend_mask_q <= pend_mask_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid  = (state_q == StInject);
    assign out_data   = out_valid ? {k_sel, PC_WIDTH'(START_PC)} : '0;
    assign round_done = (state_q == StDone);
    assign busy       = (state_q != StIdle) || pend_q;
    assign overrun    = overrun_q;

endmodule
